// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file.
// Holds the hardwired-zero address and the legal port-count ranges.
package reg_file_pkg;

    localparam int unsigned ZERO_REG = 0;

    localparam int NR_MIN = 1;
    localparam int NR_MAX = 4;
    localparam int NW_MIN = 1;
    localparam int NW_MAX = 2;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read path: zero-detect, array select and optional
// same-cycle write forwarding (REG_FILE_MP_BYPASS_EN).
// Ports: ra (address), mem_flat (regs 1..DEPTH-1 packed, reg i at
// (i-1)*WIDTH), rdata; with forwarding also we/wa/wd of all write ports.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NW    = 1
) (
    input  logic [AW-1:0]                    ra,
    input  logic [((2**AW)-1)*WIDTH-1:0]     mem_flat,
`ifdef REG_FILE_MP_BYPASS_EN
    input  logic [NW-1:0]                    we,
    input  logic [NW*AW-1:0]                 wa,
    input  logic [NW*WIDTH-1:0]              wd,
`endif
    output logic [WIDTH-1:0]                 rdata
);

    localparam int DEPTH = 2**AW;

    always_comb begin
        // Address 0 matches no stored slot, so it falls through as zero.
        rdata = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra == AW'(i)) begin
                rdata = mem_flat[(i-1)*WIDTH +: WIDTH];
            end
        end
`ifdef REG_FILE_MP_BYPASS_EN
        // Later ports override earlier ones, matching write priority.
        for (int k = 0; k < NW; k++) begin
            if (we[k] && wa[k*AW +: AW] == ra &&
                ra != AW'(ZERO_REG)) begin
                rdata = wd[k*WIDTH +: WIDTH];
            end
        end
`endif
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file, register 0 hardwired to zero.
// Ports: clk, reset (sync, active-high), we/wa/wd (NW write ports,
// higher index wins), ra/rd (NR combinational read ports), wr_conflict
// (registered same-register write collision flag).
// Optional same-cycle forwarding: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NR    = 2,
    parameter int NW    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NW-1:0]         we,
    input  logic [NW*AW-1:0]      wa,
    input  logic [NW*WIDTH-1:0]   wd,
    input  logic [NR*AW-1:0]      ra,
    output logic [NR*WIDTH-1:0]   rd,
    output logic                  wr_conflict
);

    localparam int DEPTH = 2**AW;

    if (NR < NR_MIN || NR > NR_MAX) begin : g_bad_nr
        $fatal(1, "reg_file_mp: NR out of range");
    end
    if (NW < NW_MIN || NW > NW_MAX) begin : g_bad_nw
        $fatal(1, "reg_file_mp: NW out of range");
    end

    logic [WIDTH-1:0] mem_q [1:DEPTH-1];
    logic [WIDTH-1:0] mem_d [1:DEPTH-1];
    logic             conflict_q;
    logic             conflict_d;

    logic [(DEPTH-1)*WIDTH-1:0] mem_flat;

    always_comb begin
        mem_d = mem_q;
        // Ascending port order lets the higher-indexed port win.
        for (int k = 0; k < NW; k++) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we[k] && wa[k*AW +: AW] == AW'(i)) begin
                    mem_d[i] = wd[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int a = 0; a < NW; a++) begin
            for (int b = a + 1; b < NW; b++) begin
                if (we[a] && we[b] &&
                    wa[a*AW +: AW] == wa[b*AW +: AW] &&
                    wa[a*AW +: AW] != AW'(ZERO_REG)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_flat
        assign mem_flat[(i-1)*WIDTH +: WIDTH] = mem_q[i];
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        reg_file_rd_port #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .NW    (NW)
        ) u_rd (
            .ra       (ra[j*AW +: AW]),
            .mem_flat (mem_flat),
`ifdef REG_FILE_MP_BYPASS_EN
            .we       (we),
            .wa       (wa),
            .wd       (wd),
`endif
            .rdata    (rd[j*WIDTH +: WIDTH])
        );
    end

    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (NR=3, NW=2, AW=4) against an
// array model; follows REG_FILE_MP_BYPASS_EN if defined.
module tb_reg_file_mp;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int DEPTH = 2**AW;

    logic                clk = 1'b0;
    logic                reset;
    logic [NW-1:0]       we;
    logic [NW*AW-1:0]    wa;
    logic [NW*WIDTH-1:0] wd;
    logic [NR*AW-1:0]    ra;
    logic [NR*WIDTH-1:0] rd;
    logic                wr_conflict;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic             exp_conf;

    always #5 clk = ~clk;

    reg_file_mp #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .NR    (NR),
        .NW    (NW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .ra          (ra),
        .rd          (rd),
        .wr_conflict (wr_conflict)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input int j);
        int a;
        logic [WIDTH-1:0] v;
        a = int'(ra[j*AW +: AW]);
        v = (a == 0) ? '0 : model[a];
`ifdef REG_FILE_MP_BYPASS_EN
        for (int k = 0; k < NW; k++) begin
            if (we[k] && a != 0 && int'(wa[k*AW +: AW]) == a) begin
                v = wd[k*WIDTH +: WIDTH];
            end
        end
`endif
        return v;
    endfunction

    task automatic chk_reads(input string tag);
        for (int j = 0; j < NR; j++) begin
            chk($sformatf("%s_rd%0d", tag, j), rd[j*WIDTH +: WIDTH],
                exp_rd(j));
        end
    endtask

    task automatic set_w(input int k, input bit en, input int addr,
                         input logic [WIDTH-1:0] data);
        we[k]             = en;
        wa[k*AW +: AW]    = AW'(addr);
        wd[k*WIDTH +: WIDTH] = data;
    endtask

    task automatic set_r(input int j, input int addr);
        ra[j*AW +: AW] = AW'(addr);
    endtask

    // Check pre-edge reads, clock, update model, check post-edge state.
    task automatic cycle(input string tag);
        int a0, a1;
        #1;
        chk_reads({tag, "_pre"});
        a0 = int'(wa[0 +: AW]);
        a1 = int'(wa[AW +: AW]);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            exp_conf = 1'b0;
        end else begin
            exp_conf = we[0] && we[1] && a0 == a1 && a0 != 0;
            if (we[0] && a0 != 0) model[a0] = wd[0 +: WIDTH];
            if (we[1] && a1 != 0) model[a1] = wd[WIDTH +: WIDTH];
        end
        #1;
        chk_reads({tag, "_post"});
        chk({tag, "_conf"}, WIDTH'(wr_conflict), WIDTH'(exp_conf));
    endtask

    initial begin
        reset = 1'b1;
        we = '0; wa = '0; wd = '0; ra = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_conf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reads("init");
        chk("init_conf", WIDTH'(wr_conflict), '0);

        // Reset clears a written register.
        set_w(0, 1, 5, 32'hDEADBEEF);
        set_r(0, 5); set_r(1, 0); set_r(2, 5);
        cycle("wr5");
        set_w(0, 0, 0, '0);
        reset = 1'b1;
        cycle("rst");
        reset = 1'b0;
        chk("rst_r5", rd[0 +: WIDTH], '0);

        // Back-to-back writes to reg 5, rd1 parked on address 0.
        set_w(0, 1, 5, 32'hDEADBEEF);
        cycle("bw1");
        chk("bw1_val", rd[0 +: WIDTH], 32'hDEADBEEF);
        set_w(0, 1, 5, 32'hCAFEBABE);
        cycle("bw2");
        chk("bw2_val", rd[0 +: WIDTH], 32'hCAFEBABE);
        chk("bw_zero", rd[WIDTH +: WIDTH], '0);

        // Writes to register 0 are discarded.
        set_w(0, 1, 0, 32'h12345678);
        set_w(1, 1, 0, 32'h12345678);
        set_r(0, 0); set_r(1, 0);
        cycle("z0");
        chk("z0_val", rd[0 +: WIDTH], '0);

        // Collision on reg 9: port 1 wins, flag for one cycle.
        set_w(0, 1, 9, 32'hAAAA0000);
        set_w(1, 1, 9, 32'h5555FFFF);
        set_r(0, 9);
        cycle("col9");
        chk("col9_val", rd[0 +: WIDTH], 32'h5555FFFF);
        chk("col9_flag", WIDTH'(wr_conflict), 32'd1);
        set_w(0, 0, 0, '0); set_w(1, 0, 0, '0);
        cycle("col9_clr");
        chk("col9_drop", WIDTH'(wr_conflict), '0);

        // Collision on reg 0 never raises the flag.
        set_w(0, 1, 0, 32'hAAAA0000);
        set_w(1, 1, 0, 32'h5555FFFF);
        cycle("col0");
        chk("col0_flag", WIDTH'(wr_conflict), '0);

        // Forwarding (or not) on reg 7.
        set_w(0, 0, 0, '0);
        set_w(1, 1, 7, 32'h0BADF00D);
        set_r(1, 7);
        cycle("fwd7");
        chk("fwd7_val", rd[WIDTH +: WIDTH], 32'h0BADF00D);

        // Write during reset is lost.
        set_w(0, 1, 3, 32'hFFFFFFFF);
        set_w(1, 0, 0, '0);
        set_r(2, 3);
        reset = 1'b1;
        cycle("rstw");
        reset = 1'b0;
        set_w(0, 0, 0, '0);
        cycle("rstw_after");
        chk("rstw_r3", rd[2*WIDTH +: WIDTH], '0);

        // Random traffic, small write addresses to provoke collisions.
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 24) == 0);
            for (int k = 0; k < NW; k++) begin
                set_w(k, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)), $urandom);
            end
            for (int j = 0; j < NR; j++) begin
                set_r(j, int'($urandom_range(0, DEPTH - 1)));
            end
            cycle($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
